instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 12, which sets the instruction address width.
REQ-002 The block SHALL take parameter INSTR_W, default 19, which sets the instruction word width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to begin a load.
REQ-006 The block SHALL have port base_addr, input, ADDR_W bits: first write address, sampled when start is accepted.
REQ-007 The block SHALL have port count, input, ADDR_W+1 bits: number of instructions to load (0..4096), sampled when start is accepted.
REQ-008 The block SHALL have port in_valid, input, 1 bit: byte-stream valid.
REQ-009 The block SHALL have port in_data, input, 8 bits: byte-stream data.
REQ-010 The block SHALL have port in_ready, output, 1 bit: byte-stream ready.
REQ-011 The block SHALL have port wr_en, output, 1 bit: instruction-memory write strobe.
REQ-012 The block SHALL have port wr_addr, output, ADDR_W bits: instruction-memory write address.
REQ-013 The block SHALL have port wr_data, output, INSTR_W bits: instruction-memory write data.
REQ-014 The block SHALL have port busy, output, 1 bit: a load is in progress; the CPU is held off while it is high.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when a load completes.
REQ-016 The block SHALL have port err_fmt, output, 1 bit: sticky flag for a non-zero pad bit in a first byte.
REQ-017 The block SHALL have port err_wrap, output, 1 bit: sticky flag for write-address wrap-around.

Function
REQ-018 The state machine SHALL have exactly these states: IDLE, BYTE0, BYTE1, BYTE2, WRITE, FIN.
REQ-019 In IDLE, start=1 SHALL latch base_addr and count, clear err_fmt and err_wrap, and move to BYTE0 if count is not 0, otherwise to FIN.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 A byte SHALL be transferred only on a cycle where in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly in BYTE0, BYTE1 and BYTE2.
REQ-022 Byte packing SHALL be big-endian: BYTE0 in_data[2:0] -> instr[18:16], BYTE1 -> instr[15:8], BYTE2 -> instr[7:0].
REQ-023 If BYTE0 in_data[7:3] is non-zero, the block SHALL set err_fmt, discard those bits, and continue the load.
REQ-024 A transfer in BYTE2 SHALL move to WRITE; WRITE SHALL assert wr_en for exactly one cycle, with wr_addr and wr_data registered and stable during that cycle.
REQ-025 Write latency SHALL be one cycle: wr_en is high in the cycle after the BYTE2 transfer.
REQ-026 After WRITE, the address SHALL increment modulo 2^ADDR_W and the remaining count SHALL decrement by 1.
REQ-027 If the remaining count becomes 0, the block SHALL go to FIN; otherwise it SHALL go to BYTE0.
REQ-028 An increment from 4095 to 0 while further instructions remain SHALL set err_wrap; the load SHALL continue at address 0.
REQ-029 FIN SHALL pulse done for one cycle, then return to IDLE.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 If in_valid stays low, the block SHALL hold its state and partial instruction indefinitely; there is no timeout.
REQ-032 wr_en SHALL never be asserted outside WRITE.

Reset
REQ-033 When rst=0 at a clock edge, the block SHALL enter IDLE and drive in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err_fmt=0, err_wrap=0.
REQ-034 A reset during a load SHALL discard any partial instruction and SHALL generate no further writes.
REQ-035 Reset SHALL take priority over start and over a byte transfer in the same cycle.

Structure
REQ-036 A shared package SHALL hold ADDR_W, INSTR_W, the state enum type and a BYTES_PER_INSTR=3 constant.
REQ-037 The design SHALL be a single module with no sub-modules.
REQ-038 wr_* SHALL connect directly to a write port added to the instruction memory.

Verification
REQ-039 Basic load: start with base=5 and count=2, then bytes 04 C6 14, 05 00 06 -> wr_en at addresses 5 and 6 with data 0x4C614 and 0x50006, one cycle after each third byte, then a done pulse.
REQ-040 Backpressure: in_valid toggles 1,0,0,1,0,1 -> exactly 3 bytes are accepted, one write of the correct word occurs, and no duplicate bytes are taken.
REQ-041 Zero count: start with count=0 -> busy for 1 cycle, done pulses, and no wr_en is asserted.
REQ-042 Wrap: base=4095, count=2 -> writes go to addresses 4095 then 0, err_wrap=1, and done pulses.
REQ-043 Format error plus reset: first byte 0xFF -> err_fmt=1 and data[18:16]=7; rst=0 after the second byte -> IDLE, all outputs 0, and no write.
REQ-044 Start while busy: a second start pulse mid-load is ignored, base and count are unchanged, and the original write sequence completes.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared constants and state encoding for the byte-stream instruction loader.
package instruction_loader_pkg;

    localparam int unsigned ADDR_W          = 12;
    localparam int unsigned INSTR_W         = 19;
    localparam int unsigned BYTES_PER_INSTR = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BYTE0 = 3'd1,
        BYTE1 = 3'd2,
        BYTE2 = 3'd3,
        WRITE = 3'd4,
        FIN   = 3'd5
    } state_t;

endpackage

// File: rtl/instruction_loader.sv
// Packs a big-endian byte stream into instruction words and writes them to
// consecutive instruction-memory addresses, holding the CPU off while busy.
module instruction_loader #(
    parameter int unsigned ADDR_W  = instruction_loader_pkg::ADDR_W,
    parameter int unsigned INSTR_W = instruction_loader_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W:0]    count,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               err_fmt,
    output logic               err_wrap
);
    import instruction_loader_pkg::*;

    localparam int unsigned LO_W = 8 * (BYTES_PER_INSTR - 1);
    localparam int unsigned HI_W = INSTR_W - LO_W;

    state_t            state;
    state_t            state_next;
    logic [HI_W-1:0]   hi_bits;
    logic [7:0]        mid_byte;
    logic [ADDR_W:0]   remaining;
    logic              xfer;

    // in_ready is registered and is high exactly in the BYTE states
    assign xfer = in_valid && in_ready;

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (count == '0) ? FIN : BYTE0;
            BYTE0:   if (xfer) state_next = BYTE1;
            BYTE1:   if (xfer) state_next = BYTE2;
            BYTE2:   if (xfer) state_next = WRITE;
            WRITE:   state_next = (remaining == (ADDR_W+1)'(1)) ? FIN : BYTE0;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and registered strobes decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == BYTE0) || (state_next == BYTE1) || (state_next == BYTE2);
            wr_en    <= (state_next == WRITE);
            busy     <= (state_next != IDLE);
            done     <= (state_next == FIN);
        end
    end

    // Datapath: address/count bookkeeping, byte assembly and error flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_addr   <= '0;
            wr_data   <= '0;
            hi_bits   <= '0;
            mid_byte  <= '0;
            remaining <= '0;
            err_fmt   <= 1'b0;
            err_wrap  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wr_addr   <= base_addr;
                        remaining <= count;
                        err_fmt   <= 1'b0;
                        err_wrap  <= 1'b0;
                    end
                end
                BYTE0: begin
                    if (xfer) begin
                        hi_bits <= in_data[HI_W-1:0];
                        if (in_data[7:HI_W] != '0) err_fmt <= 1'b1;
                    end
                end
                BYTE1: begin
                    if (xfer) mid_byte <= in_data;
                end
                BYTE2: begin
                    if (xfer) wr_data <= {hi_bits, mid_byte, in_data};
                end
                WRITE: begin
                    wr_addr   <= wr_addr + ADDR_W'(1);
                    remaining <= remaining - (ADDR_W+1)'(1);
                    // Wrap only matters if more words still follow
                    if ((wr_addr == '1) && (remaining != (ADDR_W+1)'(1))) err_wrap <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [18:0] wr_data;
    logic        busy;
    logic        done;
    logic        err_fmt;
    logic        err_wrap;

    int checks = 0;
    int errors = 0;

    instruction_loader #(.ADDR_W(12), .INSTR_W(19)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err_fmt(err_fmt), .err_wrap(err_wrap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] b, input logic [12:0] c);
        start = 1'b1; base_addr = b; count = c;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent = 1'b0;
        in_valid = 1'b1; in_data = b;
        for (int i = 0; i < 20 && !sent; i++) begin
            if (in_ready) sent = 1'b1;
            step();
        end
        in_valid = 1'b0; in_data = 8'h00;
        if (!sent) begin
            checks++; errors++;
            $display("FAIL send_byte timeout: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        base_addr = 12'h123; count = 13'd4;
        step(); step();
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err_fmt, err_wrap} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h busy=%b done=%b ef=%b ew=%b required all 0",
                     in_ready, wr_en, wr_addr, wr_data, busy, done, err_fmt, err_wrap);
        end
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b required 0", busy); end
    endtask

    task automatic test_basic();
        do_start(12'd5, 13'd2);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_busy: busy=%b in_ready=%b required 1 1", busy, in_ready);
        end
        send_byte(8'h04); send_byte(8'hC6);
        checks++;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL basic_early_write: wr_en=%b required 0", wr_en); end
        send_byte(8'h14);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd5 || wr_data !== 19'h4C614) begin
            errors++; $display("FAIL basic_write0: we=%b addr=%0d data=%h required 1 5 4c614", wr_en, wr_addr, wr_data);
        end
        step();
        checks++;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL basic_one_cycle_strobe: wr_en=%b required 0", wr_en); end
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h06);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd6 || wr_data !== 19'h50006) begin
            errors++; $display("FAIL basic_write1: we=%b addr=%0d data=%h required 1 6 50006", wr_en, wr_addr, wr_data);
        end
        step();
        checks++;
        if (done !== 1'b1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL basic_done: done=%b we=%b required 1 0", done, wr_en);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        logic       pat   [6];
        logic [7:0] bytes [3];
        int accepted = 0;
        int writes = 0;
        int idx = 0;
        logic [18:0] got = '0;
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bytes = '{8'h01, 8'h23, 8'h45};
        do_start(12'd100, 13'd1);
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            in_data  = pat[i] ? bytes[idx] : 8'hAA;
            if (in_valid && in_ready) begin accepted++; idx++; end
            step();
            if (wr_en) begin writes++; got = wr_data; end
        end
        in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wr_en) writes++;
        end
        checks++;
        if (accepted !== 3) begin errors++; $display("FAIL bp_accepted: got %0d required 3", accepted); end
        checks++;
        if (writes !== 1 || got !== 19'h12345) begin
            errors++; $display("FAIL bp_write: writes=%0d data=%h required 1 12345", writes, got);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_zero_count();
        do_start(12'd7, 13'd0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL zero_fin: busy=%b done=%b we=%b required 1 1 0", busy, done, wr_en);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
            errors++; $display("FAIL zero_idle: busy=%b done=%b we=%b required 0 0 0", busy, done, wr_en);
        end
    endtask

    task automatic test_wrap();
        do_start(12'd4095, 13'd2);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd4095 || wr_data !== 19'h10203 || err_wrap !== 1'b0) begin
            errors++; $display("FAIL wrap_write0: we=%b addr=%0d data=%h ew=%b required 1 4095 10203 0",
                               wr_en, wr_addr, wr_data, err_wrap);
        end
        step();
        checks++;
        if (err_wrap !== 1'b1) begin errors++; $display("FAIL wrap_flag: err_wrap=%b required 1", err_wrap); end
        send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd0 || wr_data !== 19'h40506) begin
            errors++; $display("FAIL wrap_write1: we=%b addr=%0d data=%h required 1 0 40506", wr_en, wr_addr, wr_data);
        end
        step();
        checks++;
        if (done !== 1'b1 || err_wrap !== 1'b1) begin
            errors++; $display("FAIL wrap_done: done=%b ew=%b required 1 1", done, err_wrap);
        end
        step();
    endtask

    task automatic test_fmt_reset();
        int writes = 0;
        do_start(12'd30, 13'd1);
        checks++;
        if (err_wrap !== 1'b0) begin errors++; $display("FAIL wrap_cleared: err_wrap=%b required 0", err_wrap); end
        send_byte(8'hFF);
        checks++;
        if (err_fmt !== 1'b1) begin errors++; $display("FAIL fmt_flag: err_fmt=%b required 1", err_fmt); end
        send_byte(8'h00); send_byte(8'h00);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd30 || wr_data !== 19'h70000) begin
            errors++; $display("FAIL fmt_write: we=%b addr=%0d data=%h required 1 30 70000", wr_en, wr_addr, wr_data);
        end
        step(); step();
        do_start(12'd40, 13'd1);
        checks++;
        if (err_fmt !== 1'b0) begin errors++; $display("FAIL fmt_cleared: err_fmt=%b required 0", err_fmt); end
        send_byte(8'hFF);
        send_byte(8'h12);
        rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h34;
        step();
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err_fmt, err_wrap} !== '0) begin
            errors++;
            $display("FAIL midload_reset: rdy=%b we=%b addr=%h data=%h busy=%b done=%b ef=%b ew=%b required all 0",
                     in_ready, wr_en, wr_addr, wr_data, busy, done, err_fmt, err_wrap);
        end
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 6; i++) begin
            step();
            if (wr_en || busy) writes++;
        end
        checks++;
        if (writes !== 0) begin errors++; $display("FAIL reset_no_write: activity=%0d required 0", writes); end
    endtask

    task automatic test_start_while_busy();
        do_start(12'd10, 13'd2);
        send_byte(8'h02);
        start = 1'b1; base_addr = 12'd100; count = 13'd5;
        send_byte(8'h11);
        start = 1'b0;
        send_byte(8'h22);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd10 || wr_data !== 19'h21122) begin
            errors++; $display("FAIL sb_write0: we=%b addr=%0d data=%h required 1 10 21122", wr_en, wr_addr, wr_data);
        end
        step();
        send_byte(8'h03); send_byte(8'h33); send_byte(8'h44);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd11 || wr_data !== 19'h33344) begin
            errors++; $display("FAIL sb_write1: we=%b addr=%0d data=%h required 1 11 33344", wr_en, wr_addr, wr_data);
        end
        step();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL sb_done: done=%b required 1", done); end
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL sb_idle: busy=%b required 0", busy); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0; in_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_fmt_reset();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
